pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Combines hazard-detect bubble requests,
//  EX-stage branch/jump redirects, memory busy and HALT into per-stage register enables and flushes.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_sat_cnt.sv | 19 +
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage control bundle and the fixed control patterns it takes.
package pipe_ctrl_pkg;

    localparam int DEF_CNT_W     = 2;
    localparam int DEF_DRAIN_CYC = 4;
    localparam int DEF_PERF_W    = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZ    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } ctrl_t;

    // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_HALT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter; one-cycle update latency, holds at all-ones.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; enables/flushes are
// combinational from state and inputs, halted and perf_stalls are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int PERF_W    = DEF_PERF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hzd_req,
    input  logic [CNT_W-1:0]  hzd_dist,
    input  logic              br_taken,
    input  logic              jmp,
    input  logic              mem_busy,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              halted,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bub_cnt, bub_nxt;
    logic [DRN_W-1:0] drn_cnt, drn_nxt;
    ctrl_t            ctrl;
    logic             redirect;

    assign redirect = br_taken | jmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            bub_cnt <= '0;
            drn_cnt <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
            drn_cnt <= drn_nxt;
            halted  <= (state_nxt == ST_HALTED);
        end
    end

    always_comb begin
        state_nxt = state;
        bub_nxt   = bub_cnt;
        drn_nxt   = drn_cnt;
        ctrl      = CTRL_RUN;

        // A busy memory freezes everything; pending requests stay asserted
        // because the stages feeding them are frozen too.
        if (state == ST_HALTED || mem_busy) begin
            ctrl = CTRL_FREEZE;
        end else if (redirect) begin
            ctrl      = CTRL_REDIR;
            state_nxt = ST_RUN;
            bub_nxt   = '0;
            drn_nxt   = '0;
        end else begin
            case (state)
                ST_HAZ: begin
                    ctrl    = CTRL_BUBBLE;
                    bub_nxt = bub_cnt - 1'b1;
                    if (bub_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    ctrl    = CTRL_BUBBLE;
                    drn_nxt = drn_cnt - 1'b1;
                    if (drn_cnt <= DRN_W'(1)) begin
                        state_nxt = ST_HALTED;
                    end
                end
                default: begin
                    if (halt_req) begin
                        ctrl      = CTRL_HALT;
                        drn_nxt   = DRN_W'(DRAIN_CYC);
                        state_nxt = ST_DRAIN;
                    end else if (hzd_req && (hzd_dist != '0)) begin
                        // The first bubble is issued now; HAZ covers the rest.
                        ctrl = CTRL_BUBBLE;
                        if (hzd_dist > CNT_W'(1)) begin
                            bub_nxt   = hzd_dist - 1'b1;
                            state_nxt = ST_HAZ;
                        end
                    end
                end
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_en    = ctrl.idex_en;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;

    sat_cnt #(
        .W(PERF_W)
    ) u_perf (
        .clk(clk),
        .rst(rst),
        .en (!ctrl.pc_en && (state != ST_HALTED)),
        .q  (perf_stalls)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// bubble/drain-count reference model.
module tb_pipe_ctrl;

    localparam int PW   = 4;
    localparam int DC   = 4;
    localparam int PMAX = (1 << PW) - 1;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] O_RUN = 7'b1101011;
    localparam logic [6:0] O_BUB = 7'b0001111;
    localparam logic [6:0] O_RED = 7'b1111111;
    localparam logic [6:0] O_HLT = 7'b0111111;
    localparam logic [6:0] O_FRZ = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hzd_req = 1'b0;
    logic [1:0]    hzd_dist = 2'd0;
    logic          br_taken = 1'b0;
    logic          jmp = 1'b0;
    logic          mem_busy = 1'b0;
    logic          halt_req = 1'b0;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic          halted;
    logic [PW-1:0] perf_stalls;
    logic [6:0]    outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .CNT_W    (2),
        .DRAIN_CYC(DC),
        .PERF_W   (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hzd_req    (hzd_req),
        .hzd_dist   (hzd_dist),
        .br_taken   (br_taken),
        .jmp        (jmp),
        .mem_busy   (mem_busy),
        .halt_req   (halt_req),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_en    (idex_en),
        .idex_flush (idex_flush),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
        .halted     (halted),
        .perf_stalls(perf_stalls)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    // Reference model: bubbles still owed, drain cycles still owed, halted flag.
    int         m_haz = 0;
    int         m_drain = 0;
    int         m_perf = 0;
    bit         m_halted = 1'b0;
    logic [6:0] m_e;

    function automatic logic [6:0] exp_out();
        if (m_halted || mem_busy)            return O_FRZ;
        if (br_taken || jmp)                 return O_RED;
        if (m_drain > 0 || m_haz > 0)        return O_BUB;
        if (halt_req)                        return O_HLT;
        if (hzd_req && hzd_dist != 2'd0)     return O_BUB;
        return O_RUN;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_haz    <= 0;
            m_drain  <= 0;
            m_perf   <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            m_e = exp_out();
            if (!m_e[6] && m_perf < PMAX) m_perf <= m_perf + 1;
            if (mem_busy) begin
            end else if (br_taken || jmp) begin
                m_haz   <= 0;
                m_drain <= 0;
            end else if (m_drain > 0) begin
                m_drain <= m_drain - 1;
                if (m_drain == 1) m_halted <= 1'b1;
            end else if (m_haz > 0) begin
                m_haz <= m_haz - 1;
            end else if (halt_req) begin
                m_drain <= DC;
            end else if (hzd_req && hzd_dist != 2'd0) begin
                m_haz <= int'(hzd_dist) - 1;
            end
        end
    end

    task automatic step(input bit h, input int d, input bit b, input bit j,
                        input bit m, input bit hr);
        @(posedge clk);
        #1;
        hzd_req  = h;
        hzd_dist = d[1:0];
        br_taken = b;
        jmp      = j;
        mem_busy = m;
        halt_req = hr;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        hzd_req = 0; hzd_dist = 0; br_taken = 0; jmp = 0; mem_busy = 0; halt_req = 0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (outs !== O_RUN) begin
            failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RUN);
        end
        checks++;
        if (halted !== 1'b0 || perf_stalls !== '0) begin
            failures++; $display("FAIL reset_regs halted=%b perf=%0d exp 0/0", halted, perf_stalls);
        end
    endtask

    task automatic test_hazard();
        logic [6:0] exp [3];
        exp = '{O_BUB, O_BUB, O_RUN};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            step(c == 0, 2, 0, 0, 0, 0);
            checks++;
            if (outs !== exp[c]) begin
                failures++; $display("FAIL hazard_c%0d got=%b exp=%b", c, outs, exp[c]);
            end
        end
        checks++;
        if (perf_stalls !== PW'(2)) begin
            failures++; $display("FAIL hazard_perf got=%0d exp=2", perf_stalls);
        end
    endtask

    task automatic test_hazard_busy();
        logic [6:0] exp [6];
        exp = '{O_BUB, O_FRZ, O_FRZ, O_BUB, O_BUB, O_RUN};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step(c == 0, 3, 0, 0, (c == 1 || c == 2), 0);
            checks++;
            if (outs !== exp[c]) begin
                failures++; $display("FAIL haz_busy_c%0d got=%b exp=%b", c, outs, exp[c]);
            end
        end
        checks++;
        if (perf_stalls !== PW'(5)) begin
            failures++; $display("FAIL haz_busy_perf got=%0d exp=5", perf_stalls);
        end
    endtask

    task automatic test_redirect();
        logic [6:0] exp [5];
        exp = '{O_RED, O_RUN, O_RUN, O_RED, O_RUN};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            step(c == 0 || c == 3, 3 - (c / 3), c == 0, c == 3, 0, 0);
            checks++;
            if (outs !== exp[c]) begin
                failures++; $display("FAIL redirect_c%0d got=%b exp=%b", c, outs, exp[c]);
            end
        end
        checks++;
        if (perf_stalls !== '0) begin
            failures++; $display("FAIL redirect_perf got=%0d exp=0", perf_stalls);
        end
    endtask

    task automatic test_halt_abort();
        logic [6:0] exp [5];
        exp = '{O_HLT, O_BUB, O_RED, O_RUN, O_RUN};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            step(0, 0, c == 2, 0, 0, c == 0);
            checks++;
            if (outs !== exp[c] || halted !== 1'b0) begin
                failures++;
                $display("FAIL halt_abort_c%0d got=%b halted=%b exp=%b halted=0", c, outs, halted, exp[c]);
            end
        end
    endtask

    task automatic test_halt();
        logic [6:0] exp [6];
        exp = '{O_HLT, O_BUB, O_BUB, O_BUB, O_BUB, O_FRZ};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, 0, c == 0);
            checks++;
            if (outs !== exp[c] || halted !== (c == 5)) begin
                failures++;
                $display("FAIL halt_c%0d got=%b halted=%b exp=%b halted=%0d", c, outs, halted, exp[c], c == 5);
            end
        end
        for (int c = 0; c < 10; c++) begin
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            checks++;
            if (outs !== O_FRZ || halted !== 1'b1 || perf_stalls !== PW'(5)) begin
                failures++;
                $display("FAIL halted_hold_c%0d got=%b halted=%b perf=%0d exp=%b 1 5", c, outs, halted, perf_stalls, O_FRZ);
            end
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (outs !== O_RUN || halted !== 1'b0 || perf_stalls !== '0) begin
            failures++; $display("FAIL halt_release got=%b halted=%b perf=%0d", outs, halted, perf_stalls);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            step(k == 0, 3, 0, 0, 0, k == 1);
            step(0, 0, 0, 0, 0, 0);
            #2;
            rst = 1'b1;
            #1;
            checks++;
            if (outs !== O_RUN || halted !== 1'b0 || perf_stalls !== '0) begin
                failures++;
                $display("FAIL async_rst_k%0d got=%b halted=%b perf=%0d exp=%b 0 0", k, outs, halted, perf_stalls, O_RUN);
            end
            rst = 1'b0;
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (outs !== O_RUN) begin
                failures++; $display("FAIL async_after_k%0d got=%b exp=%b", k, outs, O_RUN);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int c = 0; c < PMAX + 6; c++) step(0, 0, 0, 0, 1, 0);
        checks++;
        if (outs !== O_FRZ || perf_stalls !== PW'(PMAX)) begin
            failures++; $display("FAIL saturate got=%b perf=%0d exp=%b %0d", outs, perf_stalls, O_FRZ, PMAX);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== O_RUN || perf_stalls !== PW'(PMAX)) begin
            failures++; $display("FAIL saturate_hold got=%b perf=%0d exp=%b %0d", outs, perf_stalls, O_RUN, PMAX);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (m_halted && $urandom_range(0, 3) == 0) apply_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
            checks++;
            if (outs !== exp_out() || halted !== m_halted || perf_stalls !== PW'(m_perf)) begin
                failures++;
                $display("FAIL random_c%0d outs=%b halted=%b perf=%0d exp=%b %0d %0d",
                         c, outs, halted, perf_stalls, exp_out(), m_halted, m_perf);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hazard();
        test_hazard_busy();
        test_redirect();
        test_halt_abort();
        test_halt();
        test_async_reset();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
